seq_arith_unit: RTL

- Parametrised, multi-cycle successor to the calculator's combinational arithmetic block.
- Performs unsigned add, subtract, multiply and divide on WIDTH-bit operands.
- Uses a start/done handshake, a shift-add multiplier and a restoring divider.
- Sits between the switch/operand capture logic and the 7-segment/LED display driver. Results and flags are held stable between operations.

---
 rtl/seq_arith_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seq_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_arith_unit
// Purpose  : Multi-cycle unsigned add/sub/mul/div with start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           operation,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 carry,
    output logic                 div_by_zero,
    output logic                 busy,
    output logic                 done
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]     c_OP_ADD = 2'b00;
    localparam logic [1:0]     c_OP_SUB = 2'b01;
    localparam logic [1:0]     c_OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [1:0]             r_op;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [CW-1:0]          r_count;

    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH-1:0]       r_quot;

    logic                   w_last;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [WIDTH:0]         w_shift;
    logic                   w_ge;
    logic [WIDTH-1:0]       w_rem_next;
    logic [WIDTH-1:0]       w_quot_next;

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = r_a - r_b;
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Restoring step: bring down the next dividend bit, subtract only if it fits.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_ge        = (w_shift >= {1'b0, r_b});
    assign w_rem_next  = w_ge ? WIDTH'(w_shift - {1'b0, r_b}) : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

    always_comb begin
        w_last = 1'b0;
        case (r_op)
            c_OP_ADD, c_OP_SUB: w_last = 1'b1;
            c_OP_MUL:           w_last = (r_count == c_LAST);
            default:            w_last = (r_b == '0) || (r_count == c_LAST);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_EXEC;
            S_EXEC:  if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_EXEC);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            result      <= '0;
            remainder   <= '0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op        <= operation;
                        r_a         <= x;
                        r_b         <= y;
                        r_count     <= '0;
                        r_acc       <= '0;
                        r_mcand     <= {{WIDTH{1'b0}}, x};
                        r_mplier    <= y;
                        r_rem       <= '0;
                        r_quot      <= x;
                        remainder   <= '0;
                        carry       <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                S_EXEC: begin
                    // Both datapaths step every cycle; only the selected one is published.
                    r_count  <= r_count + CW'(1);
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_next;
                    r_quot   <= w_quot_next;
                    if (w_last) begin
                        case (r_op)
                            c_OP_ADD: begin
                                result <= {{(WIDTH-1){1'b0}}, w_sum};
                                carry  <= w_sum[WIDTH];
                            end
                            c_OP_SUB: begin
                                result <= {{WIDTH{1'b0}}, w_diff};
                                carry  <= (r_a < r_b);
                            end
                            c_OP_MUL: begin
                                result <= w_acc_next;
                            end
                            default: begin
                                if (r_b == '0) begin
                                    result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                    remainder   <= r_a;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    result    <= {{WIDTH{1'b0}}, w_quot_next};
                                    remainder <= w_rem_next;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
